// File: rtl/mdio_led_blinker_if.sv
// mdio_led_blinker_if: AXI-lite channel bundle (5b address, 16b data) between the blinker and mdio_master
//  master: drives AW/W/AR valids, addresses, write data, strobes and B/R readies
//  slave : drives AW/W/AR readies, B/R valids, responses and read data
interface mdio_led_blinker_if;
  logic        awvalid, awready;
  logic [4:0]  awaddr;
  logic        wvalid, wready;
  logic [15:0] wdata;
  logic [1:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [4:0]  araddr;
  logic        rvalid, rready;
  logic [15:0] rdata;
  logic [1:0]  rresp;
  modport master(
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave(
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mdio_led_blinker.sv
// mdio_led_blinker: sequences mdio_master over AXI-lite to blink DP838x PHY LEDs through LEDCR writes
//  clk, reset_n (async active-low), enable (1=blink, 0=stop and restore PHY LED control)
//  axi_lite    : AXI-lite master port to mdio_master
//  led_state   : last committed pattern was ON
//  busy        : transaction in flight
//  error       : sticky BRESP/RRESP error or readback mismatch
//  overrun     : sticky, blink tick arrived while a write was still pending
//  write_count : completed LEDCR writes (wrapping)
//  Define MDIO_READBACK_EN to read LEDCR back after every write and compare it.
module mdio_led_blinker #(
  parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
  parameter int unsigned BLINK_HZ        = 1,
  parameter logic [4:0]  LEDCR_ADDR      = 5'h18,
  parameter logic [15:0] ON_PATTERN      = 16'h0038,
  parameter logic [15:0] OFF_PATTERN     = 16'h003F,
  parameter logic [15:0] RESTORE_PATTERN = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  mdio_led_blinker_if.master axi_lite,
  output logic               led_state,
  output logic               busy,
  output logic               error,
  output logic               overrun,
  output logic [15:0]        write_count
);
  localparam int unsigned HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;
  state_t state;
  logic [31:0] cnt;
  logic [15:0] payload;
  logic en_q, tgt_on, pending, rearm, restore_req, svc_rst;
  logic tick, rise, fall, b_done, wr_pend;
  assign tick = enable && cnt == HALF - 1;
  assign rise = enable && !en_q;
  assign fall = !enable && en_q;
  assign b_done = axi_lite.bvalid && axi_lite.bready;
  // a blink write for the current pending request is on the bus
  assign wr_pend = !svc_rst && (state == WRITE || state == WRESP);
  assign busy = state != IDLE;
  assign axi_lite.awaddr = LEDCR_ADDR;
  assign axi_lite.araddr = LEDCR_ADDR;
  assign axi_lite.wdata = payload;
  assign axi_lite.wstrb = 2'b11;
`ifndef MDIO_READBACK_EN
  logic unused_rd;
  assign unused_rd = ^{axi_lite.arready, axi_lite.rvalid, axi_lite.rdata, axi_lite.rresp};
  assign axi_lite.arvalid = 1'b0;
  assign axi_lite.rready = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      payload <= '0;
      en_q <= 1'b0;
      tgt_on <= 1'b0;
      pending <= 1'b0;
      rearm <= 1'b0;
      restore_req <= 1'b0;
      svc_rst <= 1'b0;
      led_state <= 1'b0;
      error <= 1'b0;
      overrun <= 1'b0;
      write_count <= '0;
      axi_lite.awvalid <= 1'b0;
      axi_lite.wvalid <= 1'b0;
      axi_lite.bready <= 1'b0;
`ifdef MDIO_READBACK_EN
      axi_lite.arvalid <= 1'b0;
      axi_lite.rready <= 1'b0;
`endif
    end else begin
      en_q <= enable;
      cnt <= (enable && !tick) ? cnt + 32'd1 : '0;
      // target holds the pattern of the next blink write; OFF here so the first tick selects ON
      if (rise) tgt_on <= 1'b0;
      if (b_done) begin
        write_count <= write_count + 16'd1;
        if (axi_lite.bresp != 2'b00) error <= 1'b1;
        led_state <= payload == ON_PATTERN;
        if (svc_rst) restore_req <= 1'b0;
        else begin
          pending <= rearm;
          rearm <= 1'b0;
        end
      end
      // a tick landing on an in-flight blink write must survive that write's completion
      if (tick) begin
        tgt_on <= !tgt_on;
        pending <= 1'b1;
        if (pending) overrun <= 1'b1;
        if (pending && wr_pend && !b_done) rearm <= 1'b1;
      end
      if (fall) begin
        restore_req <= 1'b1;
        pending <= 1'b0;
        rearm <= 1'b0;
      end
      case (state)
        IDLE: if (restore_req || pending) begin
          svc_rst <= restore_req;
          payload <= restore_req ? RESTORE_PATTERN : tgt_on ? ON_PATTERN : OFF_PATTERN;
          axi_lite.awvalid <= 1'b1;
          axi_lite.wvalid <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          if (axi_lite.awready) axi_lite.awvalid <= 1'b0;
          if (axi_lite.wready) axi_lite.wvalid <= 1'b0;
          if ((!axi_lite.awvalid || axi_lite.awready) && (!axi_lite.wvalid || axi_lite.wready)) begin
            axi_lite.bready <= 1'b1;
            state <= WRESP;
          end
        end
        WRESP: if (axi_lite.bvalid) begin
          axi_lite.bready <= 1'b0;
`ifdef MDIO_READBACK_EN
          axi_lite.arvalid <= 1'b1;
          state <= READ;
`else
          state <= IDLE;
`endif
        end
`ifdef MDIO_READBACK_EN
        READ: if (axi_lite.arready) begin
          axi_lite.arvalid <= 1'b0;
          axi_lite.rready <= 1'b1;
          state <= RDATA;
        end
        RDATA: if (axi_lite.rvalid) begin
          axi_lite.rready <= 1'b0;
          if (axi_lite.rresp != 2'b00 || axi_lite.rdata != payload) error <= 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_led_blinker.sv
// tb_mdio_led_blinker: directed bench for mdio_led_blinker with an AXI-lite slave model (HALF = 500)
module tb_mdio_led_blinker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic led_state, busy, error, overrun;
  logic [15:0] write_count;
  mdio_led_blinker_if bus();
  mdio_led_blinker #(.CLK_FREQ_HZ(1000), .BLINK_HZ(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .axi_lite(bus.master),
    .led_state(led_state), .busy(busy), .error(error), .overrun(overrun), .write_count(write_count)
  );
  always #5 clk = ~clk;
  int n_run = 0, n_fail = 0;
  int cyc = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int aw_ack = 0, w_ack = 0, b_ack = 0, ar_ack = 0, r_ack = 0;
  int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0;
  int aw_lat = 3, w_lat = 3, b_lat = 3, ar_lat = 3, r_lat = 3;
  logic [1:0] bresp_cfg = 2'b00;
  logic rd_over = 1'b0;
  logic [15:0] rd_val = 16'h0000;
  logic [15:0] last_wdata = 16'h0000;
  always @(posedge clk) begin
    cyc++;
    if (bus.awvalid && bus.awready) aw_hs++;
    if (bus.wvalid && bus.wready) begin w_hs++; last_wdata = bus.wdata; end
    if (bus.bvalid && bus.bready) b_hs++;
    if (bus.arvalid && bus.arready) ar_hs++;
    if (bus.rvalid && bus.rready) r_hs++;
  end
  always @(negedge clk) begin
    if (!reset_n) begin
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 16'h0; bus.rresp = 2'b00;
      aw_ack = aw_hs; w_ack = w_hs; b_ack = b_hs; ar_ack = ar_hs; r_ack = r_hs;
      aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
    end else begin
      if (aw_hs != aw_ack) begin bus.awready = 1'b0; aw_ack = aw_hs; end
      else if (bus.awvalid && !bus.awready) begin
        if (aw_w >= aw_lat) begin bus.awready = 1'b1; aw_w = 0; end else aw_w++;
      end
      if (w_hs != w_ack) begin bus.wready = 1'b0; w_ack = w_hs; end
      else if (bus.wvalid && !bus.wready) begin
        if (w_w >= w_lat) begin bus.wready = 1'b1; w_w = 0; end else w_w++;
      end
      if (b_hs != b_ack) begin bus.bvalid = 1'b0; b_ack = b_hs; end
      else if (!bus.bvalid && aw_hs > b_hs && w_hs > b_hs) begin
        if (b_w >= b_lat) begin bus.bvalid = 1'b1; bus.bresp = bresp_cfg; b_w = 0; end else b_w++;
      end
      if (ar_hs != ar_ack) begin bus.arready = 1'b0; ar_ack = ar_hs; end
      else if (bus.arvalid && !bus.arready) begin
        if (ar_w >= ar_lat) begin bus.arready = 1'b1; ar_w = 0; end else ar_w++;
      end
      if (r_hs != r_ack) begin bus.rvalid = 1'b0; r_ack = r_hs; end
      else if (!bus.rvalid && ar_hs > r_hs) begin
        if (r_w >= r_lat) begin
          bus.rvalid = 1'b1; bus.rresp = 2'b00; bus.rdata = rd_over ? rd_val : last_wdata; r_w = 0;
        end else r_w++;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_aw(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (bus.awvalid) begin at = cyc; break; end
    end
    check("aw_seen", {31'd0, bus.awvalid}, 32'd1);
  endtask
  task automatic wait_b(input int target, input int bound);
    for (int i = 0; i < bound && b_hs < target; i++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #1 check("b_count", b_hs, target);
  endtask
  task automatic quiet(input int n, input string tag);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.awvalid || bus.wvalid || bus.arvalid) act++;
    end
    check(tag, act, 0);
  endtask
  task automatic first_drop(input logic [1:0] exp, input string tag);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!bus.awvalid || !bus.wvalid) break;
    end
    check(tag, {30'd0, bus.awvalid, bus.wvalid}, {30'd0, exp});
  endtask
  initial begin
    int t0, t, b0;
    repeat (3) @(negedge clk);
    check("rst_awvalid", {31'd0, bus.awvalid}, 0);
    check("rst_wvalid", {31'd0, bus.wvalid}, 0);
    check("rst_bready", {31'd0, bus.bready}, 0);
    check("rst_arvalid", {31'd0, bus.arvalid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_led", {31'd0, led_state}, 0);
    check("rst_wc", {16'd0, write_count}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
    wait_aw(700, t);
    check("w1_latency", t - t0, 501);
    check("w1_addr", {27'd0, bus.awaddr}, 32'h18);
    check("w1_data", {16'd0, bus.wdata}, 32'h38);
    check("w1_wvalid", {31'd0, bus.wvalid}, 1);
    check("w1_wstrb", {30'd0, bus.wstrb}, 32'h3);
    check("w1_busy", {31'd0, busy}, 1);
    wait_b(1, 50);
    check("w1_led", {31'd0, led_state}, 1);
    check("w1_wc", {16'd0, write_count}, 1);
    check("w1_busy_done", {31'd0, busy}, 0);
    wait_aw(700, t);
    check("w2_latency", t - t0, 1001);
    check("w2_data", {16'd0, bus.wdata}, 32'h3F);
    wait_b(2, 50);
    check("w2_led", {31'd0, led_state}, 0);
    check("w2_wc", {16'd0, write_count}, 2);
    aw_lat = 1; w_lat = 6;
    wait_aw(700, t);
    check("w3_data", {16'd0, bus.wdata}, 32'h38);
    first_drop(2'b01, "w3_aw_first");
    wait_b(3, 50);
    check("w3_w_hs", w_hs, 3);
    aw_lat = 6; w_lat = 1;
    wait_aw(700, t);
    check("w4_data", {16'd0, bus.wdata}, 32'h3F);
    first_drop(2'b10, "w4_w_first");
    wait_b(4, 50);
    check("w4_aw_hs", aw_hs, 4);
    check("w4_error", {31'd0, error}, 0);
    check("w4_overrun", {31'd0, overrun}, 0);
    aw_lat = 3; w_lat = 3;
    bresp_cfg = 2'b10;
    wait_aw(700, t);
    wait_b(5, 50);
    bresp_cfg = 2'b00;
    check("w5_error", {31'd0, error}, 1);
    check("w5_led", {31'd0, led_state}, 1);
    wait_aw(700, t);
    check("w6_data", {16'd0, bus.wdata}, 32'h3F);
    wait_b(6, 50);
    check("w6_error_sticky", {31'd0, error}, 1);
    check("w6_wc", {16'd0, write_count}, 6);
    b_lat = 600;
    wait_aw(700, t);
    check("w7_data", {16'd0, bus.wdata}, 32'h38);
    wait_b(7, 800);
    b_lat = 3;
    check("w7_overrun", {31'd0, overrun}, 1);
    wait_aw(20, t);
    check("w8_data", {16'd0, bus.wdata}, 32'h3F);
    wait_b(8, 50);
    check("w8_wc", {16'd0, write_count}, 8);
    quiet(100, "w8_single_extra");
    wait_aw(700, t);
    check("w9_data", {16'd0, bus.wdata}, 32'h38);
    wait_b(9, 50);
    aw_lat = 10; w_lat = 10;
    wait_aw(700, t);
    enable = 1'b0;
    check("w10_data", {16'd0, bus.wdata}, 32'h3F);
    wait_b(10, 80);
    aw_lat = 3; w_lat = 3;
    check("w10_wc", {16'd0, write_count}, 10);
    wait_aw(100, t);
    check("rst_pat_data", {16'd0, bus.wdata}, 32'h0);
    check("rst_pat_addr", {27'd0, bus.awaddr}, 32'h18);
    wait_b(11, 50);
    check("restore_led", {31'd0, led_state}, 0);
    check("restore_wc", {16'd0, write_count}, 11);
    repeat (50) @(posedge clk);
    quiet(1200, "disabled_quiet");
    check("disabled_busy", {31'd0, busy}, 0);
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
    wait_aw(700, t);
    check("re_latency", t - t0, 501);
    check("re_data", {16'd0, bus.wdata}, 32'h38);
    wait_b(12, 50);
    enable = 1'b0;
    wait_aw(100, t);
    check("re_restore_data", {16'd0, bus.wdata}, 32'h0);
    b_lat = 30;
    enable = 1'b1;
    t0 = cyc;
    wait_b(13, 80);
    b_lat = 3;
    check("inflight_led", {31'd0, led_state}, 0);
    wait_aw(700, t);
    check("resume_latency", t - t0, 501);
    check("resume_data", {16'd0, bus.wdata}, 32'h38);
    wait_b(14, 50);
    check("resume_wc", {16'd0, write_count}, 14);
    @(negedge clk);
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check("rst2_error", {31'd0, error}, 0);
    check("rst2_overrun", {31'd0, overrun}, 0);
    check("rst2_wc", {16'd0, write_count}, 0);
    check("rst2_led", {31'd0, led_state}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
`ifdef MDIO_READBACK_EN
    @(negedge clk);
    rd_over = 1'b1;
    rd_val = 16'h0030;
    b0 = b_hs;
    enable = 1'b1;
    wait_aw(700, t);
    check("rb_data", {16'd0, bus.wdata}, 32'h38);
    wait_b(b0 + 1, 50);
    repeat (20) @(posedge clk);
    #1 check("rb_mismatch_error", {31'd0, error}, 1);
`else
    b0 = b_hs;
    check("nrb_arvalid", {31'd0, bus.arvalid}, 0);
    check("nrb_b_hs", b_hs, b0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
